// File: rtl/axil_csr_pkg.sv
// rtl/axil_csr_pkg.sv - shared constants and per-byte update rule for the CSR bank
//   MODE_*  : register access modes (field value in REG_MODE)
//   RESP_*  : AXI4-Lite response codes
//   csr_next: next value of one byte lane of a register
package axil_csr_pkg;

    localparam logic [1:0] MODE_RW    = 2'd0;
    localparam logic [1:0] MODE_RO    = 2'd1;
    localparam logic [1:0] MODE_W1C   = 2'd2;
    localparam logic [1:0] MODE_PULSE = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Applied per byte lane so it stays width-independent. wstrb is the lane
    // enable of a committed AXI write; set carries user-side W1C set bits and is
    // ORed in last so a set beats a simultaneous clear.
    function automatic logic [7:0] csr_next(
        input logic [1:0] mode,
        input logic [7:0] cur,
        input logic [7:0] wdata,
        input logic       wstrb,
        input logic [7:0] set
    );
        logic [7:0] nxt;
        nxt = cur;
        case (mode)
            MODE_RW, MODE_PULSE: if (wstrb) nxt = wdata;
            MODE_W1C:            if (wstrb) nxt = cur & ~wdata;
            default:             nxt = cur;
        endcase
        return nxt | set;
    endfunction

endpackage

// File: rtl/axil_csr_wr_ctrl.sv
// rtl/axil_csr_wr_ctrl.sv - AXI4-Lite write-side buffering, commit and B response
//   clk, rst             : clock, synchronous active-high reset
//   s_axil_aw*/w*/b*     : AXI4-Lite write channels (prot handled by the top)
//   commit               : one-cycle strobe, address and data both present
//   commit_addr/data/strb: the transaction being committed (live or buffered)
//   commit_err           : decode result from the top, selects SLVERR
module axil_csr_wr_ctrl
    import axil_csr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    output logic                  commit,
    output logic [ADDR_WIDTH-1:0] commit_addr,
    output logic [DATA_WIDTH-1:0] commit_data,
    output logic [STRB_WIDTH-1:0] commit_strb,
    input  logic                  commit_err
);

    logic                  aw_full;
    logic                  w_full;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  aw_hs;
    logic                  w_hs;

    // Buffers stay full until the B handshake, which is what holds the
    // ready lines low for the whole transaction.
    assign s_axil_awready = !aw_full;
    assign s_axil_wready  = !w_full;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;

    assign aw_hs = s_axil_awvalid && !aw_full;
    assign w_hs  = s_axil_wvalid && !w_full;

    assign commit      = (aw_full || aw_hs) && (w_full || w_hs) && !bvalid_q;
    assign commit_addr = aw_full ? addr_q : s_axil_awaddr;
    assign commit_data = w_full ? data_q : s_axil_wdata;
    assign commit_strb = w_full ? strb_q : s_axil_wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                addr_q  <= s_axil_awaddr;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                data_q <= s_axil_wdata;
                strb_q <= s_axil_wstrb;
            end
            // A commit always captures any live channel above, so both
            // buffers are full whenever bvalid is high.
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= commit_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && s_axil_bready) begin
                bvalid_q <= 1'b0;
                bresp_q  <= RESP_OKAY;
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axil_csr_bank.sv
// rtl/axil_csr_bank.sv - AXI4-Lite register bank with per-register access modes
//   clk, rst      : clock, synchronous active-high reset
//   user_write    : per-register user write enable
//   user_wdata    : user write data, register i at slice i
//   user_rdata    : current register contents, register i at slice i
//   reg_wr_pulse  : one-cycle pulse after an AXI write commits to register i
//   s_axil_*      : AXI4-Lite slave (prot inputs ignored)
module axil_csr_bank
    import axil_csr_pkg::*;
#(
    parameter int                              DATA_WIDTH = 32,
    parameter int                              ADDR_WIDTH = 32,
    parameter int                              STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                              REG_NUM    = 32,
    parameter logic [2*REG_NUM-1:0]            REG_MODE   = '0,
    parameter logic [DATA_WIDTH*REG_NUM-1:0]   RESET_VAL  = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REG_NUM-1:0]            user_write,
    input  logic [DATA_WIDTH*REG_NUM-1:0] user_wdata,
    output logic [DATA_WIDTH*REG_NUM-1:0] user_rdata,
    output logic [REG_NUM-1:0]            reg_wr_pulse,
    input  logic [ADDR_WIDTH-1:0]         s_axil_awaddr,
    input  logic [2:0]                    s_axil_awprot,
    input  logic                          s_axil_awvalid,
    output logic                          s_axil_awready,
    input  logic [DATA_WIDTH-1:0]         s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]         s_axil_wstrb,
    input  logic                          s_axil_wvalid,
    output logic                          s_axil_wready,
    output logic [1:0]                    s_axil_bresp,
    output logic                          s_axil_bvalid,
    input  logic                          s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]         s_axil_araddr,
    input  logic [2:0]                    s_axil_arprot,
    input  logic                          s_axil_arvalid,
    output logic                          s_axil_arready,
    output logic [DATA_WIDTH-1:0]         s_axil_rdata,
    output logic [1:0]                    s_axil_rresp,
    output logic                          s_axil_rvalid,
    input  logic                          s_axil_rready
);

    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int IDX_W    = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    // Bits below ADDR_LSB+IDX_W may be anything; any bit above is unmapped.
    localparam logic [ADDR_WIDTH-1:0] LO_MASK   = ADDR_WIDTH'((64'd1 << (ADDR_LSB + IDX_W)) - 64'd1);
    localparam logic [IDX_W:0]        REG_NUM_L = (IDX_W + 1)'(REG_NUM);

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return ((a & ~LO_MASK) == '0) && ({1'b0, a[ADDR_LSB +: IDX_W]} < REG_NUM_L);
    endfunction

    logic                          commit;
    logic [ADDR_WIDTH-1:0]         commit_addr;
    logic [DATA_WIDTH-1:0]         commit_data;
    logic [STRB_WIDTH-1:0]         commit_strb;
    logic                          wr_ok;
    logic [IDX_W-1:0]              wr_idx;
    logic [DATA_WIDTH*REG_NUM-1:0] regs_q;
    logic [DATA_WIDTH*REG_NUM-1:0] regs_nxt;
    logic [REG_NUM-1:0]            pulse_nxt;
    logic                          rvalid_q;
    logic [DATA_WIDTH-1:0]         rdata_q;
    logic [1:0]                    rresp_q;
    logic                          ar_hs;
    logic                          rd_ok;
    logic [IDX_W-1:0]              rd_idx;
    logic                          unused_prot;

    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    axil_csr_wr_ctrl #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .STRB_WIDTH(STRB_WIDTH)
    ) u_wr_ctrl (
        .clk           (clk),
        .rst           (rst),
        .s_axil_awaddr (s_axil_awaddr),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata  (s_axil_wdata),
        .s_axil_wstrb  (s_axil_wstrb),
        .s_axil_wvalid (s_axil_wvalid),
        .s_axil_wready (s_axil_wready),
        .s_axil_bresp  (s_axil_bresp),
        .s_axil_bvalid (s_axil_bvalid),
        .s_axil_bready (s_axil_bready),
        .commit        (commit),
        .commit_addr   (commit_addr),
        .commit_data   (commit_data),
        .commit_strb   (commit_strb),
        .commit_err    (!wr_ok)
    );

    assign wr_ok  = addr_ok(commit_addr);
    assign wr_idx = commit_addr[ADDR_LSB +: IDX_W];

    for (genvar i = 0; i < REG_NUM; i++) begin : gen_reg
        localparam logic [1:0]            MODE   = REG_MODE[2*i +: 2];
        localparam logic [DATA_WIDTH-1:0] RST    = RESET_VAL[DATA_WIDTH*i +: DATA_WIDTH];
        localparam logic [IDX_W-1:0]      MY_IDX = IDX_W'(i);

        logic                  hit;
        logic [DATA_WIDTH-1:0] cur;
        logic [DATA_WIDTH-1:0] usr;
        logic [DATA_WIDTH-1:0] set_bits;
        logic [DATA_WIDTH-1:0] nxt;

        assign hit = commit && wr_ok && (wr_idx == MY_IDX);
        assign cur = regs_q[DATA_WIDTH*i +: DATA_WIDTH];
        assign usr = user_wdata[DATA_WIDTH*i +: DATA_WIDTH];

        always_comb begin
            set_bits = (MODE == MODE_W1C && user_write[i]) ? usr : '0;
            nxt      = cur;
            for (int b = 0; b < STRB_WIDTH; b++) begin
                nxt[8*b +: 8] = csr_next(MODE, cur[8*b +: 8], commit_data[8*b +: 8],
                                         hit && commit_strb[b], set_bits[8*b +: 8]);
            end
            // User port overrides AXI outright except on W1C, where it sets bits.
            if (MODE != MODE_W1C && user_write[i]) begin
                nxt = usr;
            end else if (MODE == MODE_PULSE && !hit) begin
                nxt = RST;
            end
        end

        assign regs_nxt[DATA_WIDTH*i +: DATA_WIDTH] = nxt;
        assign pulse_nxt[i] = hit && (MODE != MODE_RO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q       <= RESET_VAL;
            reg_wr_pulse <= '0;
        end else begin
            regs_q       <= regs_nxt;
            reg_wr_pulse <= pulse_nxt;
        end
    end

    assign user_rdata = regs_q;

    // Read path: a new request is taken whenever the output slot is free or
    // being drained this cycle, so back-to-back reads run at one per cycle.
    assign s_axil_arready = !rvalid_q || s_axil_rready;
    assign ar_hs          = s_axil_arvalid && s_axil_arready;
    assign rd_ok          = addr_ok(s_axil_araddr);
    assign rd_idx         = s_axil_araddr[ADDR_LSB +: IDX_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_ok ? regs_q[rd_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
            rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axil_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rdata  = rdata_q;
    assign s_axil_rresp  = rresp_q;

endmodule

// File: tb/tb_axil_csr_bank.sv
// tb/tb_axil_csr_bank.sv - scoreboard bench for axil_csr_bank
module tb_axil_csr_bank;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int NR = 5;
    // reg0 RW, reg1 RO, reg2 RW, reg3 W1C, reg4 PULSE
    localparam logic [2*NR-1:0]  MODES = 10'h384;
    localparam logic [DW*NR-1:0] RSTV  = {32'h000000A5, 32'h0000000F, 32'h00000000,
                                          32'h12345678, 32'h00000000};

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     user_write;
    logic [DW*NR-1:0]  user_wdata;
    logic [DW*NR-1:0]  user_rdata;
    logic [NR-1:0]     reg_wr_pulse;
    logic [AW-1:0]     awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [SW-1:0]     wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AW-1:0]     araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    axil_csr_bank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .REG_NUM(NR),
        .REG_MODE(MODES), .RESET_VAL(RSTV)
    ) dut (
        .clk(clk), .rst(rst),
        .user_write(user_write), .user_wdata(user_wdata), .user_rdata(user_rdata),
        .reg_wr_pulse(reg_wr_pulse),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
        .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0]  exp_bq[$];
    logic [33:0] exp_rq[$];

    logic [NR-1:0]    snap_pulse, snap_pulse2;
    logic [DW*NR-1:0] snap_regs, snap_regs2;

    function automatic void chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] reg_of(input logic [DW*NR-1:0] v, input int i);
        return v[32*i +: 32];
    endfunction

    // Monitor: pops expected responses whenever the DUT completes a handshake
    logic        hold_valid = 1'b0;
    logic [33:0] hold_val   = '0;
    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            if (bvalid && bready) begin
                if (exp_bq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL b_unexpected: got bresp %0h expected no response", bresp);
                end else begin
                    chk("bresp", 160'(bresp), 160'(exp_bq.pop_front()));
                end
            end
            if (rvalid) begin
                if (hold_valid) chk("r_hold", 160'({rresp, rdata}), 160'(hold_val));
                if (rready) begin
                    hold_valid = 1'b0;
                    if (exp_rq.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL r_unexpected: got %0h expected no response", {rresp, rdata});
                    end else begin
                        chk("rresp_rdata", 160'({rresp, rdata}), 160'(exp_rq.pop_front()));
                    end
                end else begin
                    hold_valid = 1'b1;
                    hold_val   = {rresp, rdata};
                end
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] resp, input logic [NR-1:0] uw, input logic [DW*NR-1:0] ud);
        bit a_done = 0, w_done = 0, a_hs, w_hs;
        exp_bq.push_back(resp);
        @(posedge clk); #1;
        awaddr = addr; awvalid = 1; wdata = data; wstrb = strb; wvalid = 1; bready = 1;
        user_write = uw; user_wdata = ud;
        for (int cyc = 0; cyc < 20 && !(a_done && w_done); cyc++) begin
            @(negedge clk);
            a_hs = awvalid && awready;
            w_hs = wvalid && wready;
            @(posedge clk); #1;
            user_write = '0;
            if (a_hs) begin a_done = 1; awvalid = 0; end
            if (w_hs) begin w_done = 1; wvalid = 0; end
        end
        awvalid = 0; wvalid = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bvalid) break;
        end
        if (!bvalid) begin
            n_cmp++; n_fail++;
            $display("FAIL b_timeout: got no bvalid expected bvalid within 20 cycles");
        end
        snap_pulse = reg_wr_pulse; snap_regs = user_rdata;
        @(posedge clk); #1;
        bready = 0;
        @(negedge clk);
        snap_pulse2 = reg_wr_pulse; snap_regs2 = user_rdata;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit hs;
        exp_rq.push_back({exp_resp, exp_data});
        @(posedge clk); #1;
        araddr = addr; arvalid = 1; rready = 1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            hs = arvalid && arready;
            @(posedge clk); #1;
            if (hs) break;
        end
        arvalid = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (rvalid) break;
        end
        @(posedge clk); #1;
        rready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [DW*NR-1:0] ud;
    logic [31:0]      bp_addr [4];
    logic [31:0]      bp_data [4];

    initial begin
        rst = 1; user_write = '0; user_wdata = '0;
        awaddr = '0; awprot = 3'b0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arprot = 3'b0; arvalid = 0; rready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 160'(awready), 160'(1'b1));
        chk("rst_wready", 160'(wready), 160'(1'b1));
        chk("rst_arready", 160'(arready), 160'(1'b1));
        chk("rst_bvalid_rvalid", 160'({bvalid, rvalid}), 160'(2'b00));
        chk("rst_resp_rdata", 160'({bresp, rresp, rdata}), 160'(36'h0));
        chk("rst_pulse", 160'(reg_wr_pulse), 160'(5'b0));
        chk("rst_regs", 160'(user_rdata), 160'(RSTV));
        @(posedge clk); #1;
        rst = 0;

        // RW with byte strobes
        axi_write(32'h08, 32'hAABBCCDD, 4'b0101, 2'b00, '0, '0);
        chk("rw_reg2", 160'(reg_of(snap_regs, 2)), 160'(32'h00BB00DD));
        chk("rw_pulse", 160'(snap_pulse), 160'(5'b00100));
        chk("rw_pulse_gone", 160'(snap_pulse2), 160'(5'b00000));
        axi_read(32'h08, 32'h00BB00DD, 2'b00);

        // W1C clear colliding with a user set
        ud = '0; ud[96 +: 32] = 32'h1;
        axi_write(32'h0C, 32'h3, 4'hF, 2'b00, 5'b01000, ud);
        chk("w1c_reg3", 160'(reg_of(snap_regs, 3)), 160'(32'hD));
        chk("w1c_pulse", 160'(snap_pulse), 160'(5'b01000));

        // AW early, W late, B back-pressured
        exp_bq.push_back(2'b00);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            awaddr = 32'h0; awvalid = (c == 0);
            wdata = 32'h11223344; wstrb = 4'hF; wvalid = (c == 3);
            bready = (c == 6);
            @(negedge clk);
            chk($sformatf("early_awready_c%0d", c), 160'(awready), 160'(c == 0 || c == 7));
            chk($sformatf("early_bvalid_c%0d", c), 160'(bvalid), 160'(c >= 4 && c <= 6));
            chk($sformatf("early_wready_c%0d", c), 160'(wready), 160'(c <= 3 || c == 7));
            if (c == 3) chk("early_reg0_before", 160'(reg_of(user_rdata, 0)), 160'(32'h0));
            if (c == 4) chk("early_reg0_after", 160'(reg_of(user_rdata, 0)), 160'(32'h11223344));
            if (c == 4) chk("early_pulse", 160'(reg_wr_pulse), 160'(5'b00001));
            if (c == 5) chk("early_pulse_gone", 160'(reg_wr_pulse), 160'(5'b00000));
        end
        @(posedge clk); #1;
        bready = 0;

        // Unmapped accesses
        axi_write(32'h14, 32'hFFFFFFFF, 4'hF, 2'b10, '0, '0);
        chk("unmap_pulse", 160'(snap_pulse), 160'(5'b0));
        chk("unmap_regs", 160'(snap_regs2), 160'({32'hA5, 32'hD, 32'h00BB00DD, 32'h12345678, 32'h11223344}));
        axi_read(32'h18, 32'h0, 2'b10);
        axi_read(32'h20, 32'h0, 2'b10);
        axi_read(32'h10, 32'hA5, 2'b00);

        // Back-to-back reads with rready low for one cycle
        bp_addr = '{32'h00, 32'h04, 32'h08, 32'h0C};
        bp_data = '{32'h11223344, 32'h12345678, 32'h00BB00DD, 32'h0000000D};
        begin
            int idx = 0;
            bit hs;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                arvalid = (idx < 4);
                araddr  = (idx < 4) ? bp_addr[idx] : 32'h0;
                rready  = (c != 2);
                @(negedge clk);
                chk($sformatf("bp_arready_c%0d", c), 160'(arready), 160'(c != 2));
                hs = arvalid && arready;
                if (hs) begin
                    exp_rq.push_back({2'b00, bp_data[idx]});
                    idx++;
                end
            end
            @(posedge clk); #1;
            arvalid = 0; rready = 0;
        end

        // PULSE register
        axi_write(32'h10, 32'h1, 4'hF, 2'b00, '0, '0);
        chk("pulse_reg4_on", 160'(reg_of(snap_regs, 4)), 160'(32'h1));
        chk("pulse_reg4_off", 160'(reg_of(snap_regs2, 4)), 160'(32'hA5));
        chk("pulse_strobe", 160'(snap_pulse), 160'(5'b10000));

        // RO register
        axi_write(32'h04, 32'hFFFFFFFF, 4'hF, 2'b00, '0, '0);
        chk("ro_reg1", 160'(reg_of(snap_regs, 1)), 160'(32'h12345678));
        chk("ro_pulse", 160'(snap_pulse), 160'(5'b0));

        // Reset in the middle of a write: buffered AW must be discarded
        @(posedge clk); #1;
        awaddr = 32'h0; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("midrst_awready", 160'(awready), 160'(1'b1));
        chk("midrst_bvalid", 160'(bvalid), 160'(1'b0));
        chk("midrst_regs", 160'(user_rdata), 160'(RSTV));
        axi_write(32'h00, 32'h55, 4'hF, 2'b00, '0, '0);
        chk("post_rst_reg0", 160'(reg_of(snap_regs, 0)), 160'(32'h55));

        repeat (3) @(posedge clk);
        chk("b_queue_empty", 160'(exp_bq.size()), 160'(0));
        chk("r_queue_empty", 160'(exp_rq.size()), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_csr_bank.md
Name: axil_csr_bank

Overview:
AXI4-Lite slave register bank that supersedes the plain regfile for the datapath control/status space.
- Per-register access modes: RW, RO, W1C, PULSE.
- Byte-strobe writes.
- SLVERR for unmapped addresses.
- One-cycle write-notify strobes toward user logic.
- User logic keeps a parallel write path for status updates. Sits between the AXI-Lite interconnect and the core control logic.

Parameters:
- DATA_WIDTH, 32, register and AXI data width; multiple of 8.
- ADDR_WIDTH, 32, AXI address width.
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width.
- REG_NUM, 32, number of registers; any value ≥ 1, need not be a power of 2.
- REG_MODE, all zeros, 2*REG_NUM bits; field i selects the mode of register i: 0 = RW, 1 = RO, 2 = W1C, 3 = PULSE.
- RESET_VAL, all zeros, DATA_WIDTH*REG_NUM bits; reset value of each register.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- user_write  in  REG_NUM  per-register user write enable.
- user_wdata  in  DATA_WIDTH*REG_NUM  user write data, register i at slice i.
- user_rdata  out  DATA_WIDTH*REG_NUM  current register contents.
- reg_wr_pulse  out  REG_NUM  one-cycle pulse when an AXI write commits to register i.
- s_axil_aw{addr,prot,valid,ready}, s_axil_w{data,strb,valid,ready}, s_axil_b{resp,valid,ready}: standard AXI4-Lite write channels.
- s_axil_ar{addr,prot,valid,ready}, s_axil_r{data,resp,valid,ready}: standard AXI4-Lite read channels.
- prot inputs are ignored.

Behaviour:
- Addressing:
  - ADDR_LSB = $clog2(STRB_WIDTH); IDX_W = max(1, $clog2(REG_NUM)).
  - Register index = addr[ADDR_LSB +: IDX_W].
  - Address is unmapped if index ≥ REG_NUM or any addr bit above ADDR_LSB+IDX_W is set.
- Reset outputs: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, reg_wr_pulse=0, registers=RESET_VAL.
- Write channel:
  - AW and W are accepted independently; each has a one-entry holding buffer.
  - awready drops the cycle after AW is captured and stays low until the B handshake; wready behaves the same for W.
  - Commit happens in the first cycle where both address and data are available (live or buffered) and bvalid=0.
  - bvalid rises the next cycle. AW and W in the same cycle give bvalid at T+1.
  - Back-to-back writes: awready/wready return to 1 in the cycle after bvalid&bready, so throughput is one write per 2 cycles minimum.
  - bvalid holds until bready.
  - bresp: 2'b00 if mapped, 2'b10 (SLVERR) if unmapped. An unmapped write changes no state.
- Write semantics per mode, byte lanes selected by wstrb:
  - RW: selected bytes replaced.
  - RO: AXI write ignored; bresp OKAY; no pulse.
  - W1C: bits written 1 in selected bytes are cleared.
  - PULSE: selected bytes loaded for exactly one cycle, then the register returns to RESET_VAL.
- reg_wr_pulse[i] is asserted in the cycle after commit, for mapped non-RO registers only.
- User-write priority, same cycle as an AXI commit:
  - RW/RO/PULSE: user_write wins and the register takes user_wdata.
  - W1C: user_write ORs user_wdata into the register (set); set wins over a simultaneous clear on the same bit.
- Read channel:
  - arready = !rvalid || rready, combinational from the registered rvalid. This gives full throughput of one read per cycle.
  - On an AR handshake: rdata, rresp and rvalid are registered at T+1.
  - Data is sampled from the register state before any same-cycle write (old value).
  - Unmapped read: rdata=0, rresp=2'b10.
  - rvalid/rdata hold stable while rready=0.
  - Reads have no side effects, including on W1C registers.
- rst mid-transaction: all buffers are discarded, no response is issued, and outputs return to reset values on the next edge.

Decomposition:
- Package axil_csr_pkg holds:
  - Mode constants MODE_RW/MODE_RO/MODE_W1C/MODE_PULSE.
  - AXI resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Function csr_next(mode, cur, wdata, wstrb, set) returning the next register value.
- Sub-module axil_csr_wr_ctrl: AW/W buffering, commit and B response. The register array and read path stay in the top.

Test Plan:
- RW strobe: REG_NUM=8, reg2 RW reset 0; write 0xAABBCCDD to addr 0x08 with wstrb=4'b0101 → bresp=0, reg2=0x00BB00DD, reg_wr_pulse=8'h04 for one cycle; readback rdata=0x00BB00DD.
- W1C plus set collision: reg3 W1C holds 0xF; AXI write 0x3 to 0x0C in the same commit cycle as user_write[3] with data 0x1 → reg3=0xD.
- AW early: AW at cycle 0, W at cycle 3, bready=0 until cycle 6 → awready=0 for cycles 1–6, bvalid at cycle 4 held to 6, commit at cycle 3 only.
- Unmapped: REG_NUM=5; write to 0x14 → bresp=2'b10 and no state change; read 0x18 → rdata=0, rresp=2'b10.
- Read backpressure: 4 back-to-back ARs with rready toggling 1,0,1,1 → each rdata presented in order, held stable while rready=0, arready low exactly when rvalid&&!rready.
- PULSE/RO: write 0x1 to a PULSE reg → user_rdata shows 0x1 for one cycle then RESET_VAL; write to an RO reg → value unchanged, bresp=0, no reg_wr_pulse.
